cellrv32_trng_ctrl: RTL
=======================

Name: cellrv32_trng_ctrl

Overview:
Controller and scheduler for the cellTRNG entropy source.
- Sequences the TRNG enable and discards warm-up bytes.
- Runs a repetition-count health test on the raw byte stream.
- Packs bytes into 32-bit words and buffers them in a word FIFO.
- Shares the FIFO between two requesters (CPU bus port, crypto accelerator) using round-robin arbitration.

Parameters:
FIFO_DEPTH, 4, word FIFO depth; power of 2, >= 2
WARMUP_BYTES, 64, number of valid TRNG bytes discarded after each enable; >= 1
REP_LIMIT, 16, number of consecutive identical bytes that declares a fault; >= 2

Ports:
clk_i  in  1  global clock
rstn_i  in  1  global reset, asynchronous, active-low
en_i  in  1  controller enable; low = off and flush
trng_en_o  out  1  drives cellTRNG enable_i
trng_data_i  in  8  cellTRNG data_o
trng_valid_i  in  1  cellTRNG valid_o, single-cycle pulse
req_i  in  2  level request per requester (bit0 = CPU, bit1 = crypto)
gnt_o  out  2  one-hot grant pulse; data_o valid in the same cycle
data_o  out  32  granted random word
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO fill level
ready_o  out  1  high when state is RUN
err_o  out  1  health-test fault, sticky

Behaviour:
- Reset values: trng_en_o=0, gnt_o=0, data_o=0, level_o=0, ready_o=0, err_o=0. State=OFF, RR pointer=0, counters and assembly register cleared.
- OFF: trng_en_o=0.
  - en_i=1 -> WARMUP; trng_en_o=1 from the next cycle.
- WARMUP: count trng_valid_i pulses.
  - On the WARMUP_BYTES-th pulse -> RUN; that byte is also discarded.
  - The health test is inactive in WARMUP.
- RUN: each valid byte is shifted into the assembly register, little-endian: first byte -> [7:0], fourth byte -> [31:24].
  - On the 4th byte, the word is pushed to the FIFO in the same cycle.
  - If the FIFO is full on a valid byte, the byte is dropped, the byte index is not advanced, and the health test still evaluates it.
- Health test (RUN only):
  - Track the last byte and a repeat counter (counter=1 on a new value).
  - When the counter reaches REP_LIMIT -> FAULT: err_o=1, trng_en_o=0, FIFO flushed, assembly cleared, ready_o=0.
  - The faulting byte is not pushed.
- FAULT: held until en_i=0, then -> OFF. err_o clears on the FAULT->OFF transition.
- en_i=0 in WARMUP or RUN:
  - Next cycle: state=OFF, trng_en_o=0, FIFO flushed, assembly and counters cleared.
  - A grant already in flight still completes.
- Arbitration:
  - In cycle N, if the FIFO is non-empty and req_i != 0, pop one word and pick the requester.
  - If both request, pick the one indicated by the RR pointer; after a grant to i, the pointer moves to 1-i.
  - Registered outputs: gnt_o one-hot and data_o at N+1 for one cycle. data_o holds its last value otherwise.
  - At most one grant per cycle. Requests are sampled every cycle, so a requester must deassert req_i in the cycle gnt_o is seen, or it may receive a further word.
  - Empty FIFO: requests wait and no grant is issued.
  - Grants are issued only in RUN.
- FIFO behaviour:
  - Push and pop in the same cycle are both performed and the level is unchanged.
  - A push into an empty FIFO is poppable from the next cycle.
  - level_o is registered and reflects the post-update count.
  - Pointers wrap modulo FIFO_DEPTH; full is level==FIFO_DEPTH.
  - Flush has priority over push and pop in the same cycle.
- Latency:
  - trng_valid_i completing a word -> level_o increments the next cycle.
  - req_i to gnt_o is 1 cycle minimum.

Decomposition:
- cellrv32_package: enum trng_ctrl_state_t {OFF, WARMUP, RUN, FAULT}, plus a localparam for the word width (32).
- One sub-module, cellrv32_trng_fifo: synchronous word FIFO with push, pop, flush, level, full and empty. It is parameterised by FIFO_DEPTH and uses the same clock and async active-low reset.
- Arbiter, FSM, packer and health test stay in the top module.

Test Plan:
- Enable with WARMUP_BYTES=4 and feed bytes 01..0C with trng_valid_i pulses. Required: bytes 01..04 are discarded, FIFO holds 0x08070605 and 0x0C0B0A09, and level_o=2.
- Hold req_i=2'b11 with 4 words queued. Required: grants alternate 01,10,01,10 starting with CPU, data_o is FIFO order, and level_o reaches 0 with no further gnt_o.
- Fill the FIFO (DEPTH=4, 16 bytes), then feed 4 more bytes. Required: those bytes are dropped, level_o=4, and after one pop the next 4 bytes form the following word.
- Feed REP_LIMIT=16 bytes of value 0xAA in RUN. Required: on the 16th byte err_o=1, trng_en_o=0, level_o=0, and gnt_o stays 0. Then en_i=0 gives err_o=0 and state OFF.
- Drop en_i mid-word (2 bytes assembled, level_o=3). Required: next cycle level_o=0 and trng_en_o=0. Re-enable runs the full warm-up again.
- Pulse rstn_i low mid-grant. Required: all outputs go to reset values immediately, asynchronously.

Source files
------------

// File: rtl/cellrv32_trng_ctrl_pkg.sv
// rtl/cellrv32_trng_ctrl_pkg.sv - shared types and constants for the TRNG controller
package cellrv32_trng_ctrl_pkg;

  localparam int TRNG_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } trng_ctrl_state_t;

endpackage

// File: rtl/cellrv32_trng_fifo.sv
// rtl/cellrv32_trng_fifo.sv - word FIFO with push, pop, flush and registered level
module cellrv32_trng_fifo
  import cellrv32_trng_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [TRNG_WORD_W-1:0]        wdata_i,
  input  logic                          pop_i,
  output logic [TRNG_WORD_W-1:0]        rdata_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [TRNG_WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          rptr_q, rptr_d;
  logic [LW-1:0]          level_q, level_d;

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);

  // Next pointers and level; flush wins over any push or pop in the same cycle.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Storage array; written only on an accepted push, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/cellrv32_trng_ctrl.sv
// rtl/cellrv32_trng_ctrl.sv - TRNG sequencer, health test, byte packer and round-robin word arbiter
module cellrv32_trng_ctrl
  import cellrv32_trng_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int WARMUP_BYTES = 64,
  parameter int REP_LIMIT    = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          en_i,
  output logic                          trng_en_o,
  input  logic [7:0]                    trng_data_i,
  input  logic                          trng_valid_i,
  input  logic [1:0]                    req_i,
  output logic [1:0]                    gnt_o,
  output logic [TRNG_WORD_W-1:0]        data_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          ready_o,
  output logic                          err_o
);

  localparam int WW = $clog2(WARMUP_BYTES + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  trng_ctrl_state_t       state_q, state_d;
  logic                   trng_en_q, trng_en_d;
  logic                   err_q, err_d;
  logic [WW-1:0]          warm_cnt_q, warm_cnt_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [23:0]            asm_q, asm_d;
  logic [7:0]             last_byte_q, last_byte_d;
  logic [RW-1:0]          rep_cnt_q, rep_cnt_d;
  logic [RW-1:0]          rep_next;
  logic [1:0]             gnt_q, gnt_d;
  logic [TRNG_WORD_W-1:0] data_q, data_d;
  logic                   rr_q, rr_d;

  logic                   fifo_push, fifo_pop, fifo_flush;
  logic                   fifo_full, fifo_empty;
  logic [TRNG_WORD_W-1:0] fifo_rdata;
  logic                   pick;

  assign trng_en_o = trng_en_q;
  assign err_o     = err_q;
  assign ready_o   = (state_q == ST_RUN);
  assign gnt_o     = gnt_q;
  assign data_o    = data_q;

  // A repeat only extends a run that has already started; a zero count means no history.
  assign rep_next = ((rep_cnt_q != '0) && (trng_data_i == last_byte_q)) ? rep_cnt_q + RW'(1) : RW'(1);

  // Sequencer, health test and byte packer.
  always_comb begin
    state_d     = state_q;
    trng_en_d   = trng_en_q;
    err_d       = err_q;
    warm_cnt_d  = warm_cnt_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    last_byte_d = last_byte_q;
    rep_cnt_d   = rep_cnt_q;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (en_i) begin
          state_d   = ST_WARMUP;
          trng_en_d = 1'b1;
        end
      end
      ST_WARMUP, ST_RUN: begin
        if (!en_i || (state_q == ST_RUN && trng_valid_i && rep_next == RW'(REP_LIMIT))) begin
          state_d     = en_i ? ST_FAULT : ST_OFF;
          err_d       = en_i;
          trng_en_d   = 1'b0;
          fifo_flush  = 1'b1;
          warm_cnt_d  = '0;
          byte_idx_d  = '0;
          asm_d       = '0;
          last_byte_d = '0;
          rep_cnt_d   = '0;
        end else if (trng_valid_i && state_q == ST_WARMUP) begin
          if (warm_cnt_q == WW'(WARMUP_BYTES - 1)) begin
            state_d    = ST_RUN;
            warm_cnt_d = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + WW'(1);
          end
        end else if (trng_valid_i) begin
          last_byte_d = trng_data_i;
          rep_cnt_d   = rep_next;
          // A full FIFO drops the byte without advancing the index.
          if (!fifo_full) begin
            case (byte_idx_q)
              2'd0: asm_d[7:0]   = trng_data_i;
              2'd1: asm_d[15:8]  = trng_data_i;
              2'd2: asm_d[23:16] = trng_data_i;
              default: begin
                fifo_push = 1'b1;
                asm_d     = '0;
              end
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      default: begin
        if (!en_i) begin
          state_d = ST_OFF;
          err_d   = 1'b0;
        end
      end
    endcase
  end

  // Round-robin arbiter: pop one word per cycle, grant and data registered for the next cycle.
  always_comb begin
    fifo_pop = (state_q == ST_RUN) && !fifo_empty && (req_i != 2'b00);
    pick     = (req_i == 2'b11) ? rr_q : req_i[1];
    gnt_d    = 2'b00;
    data_d   = data_q;
    rr_d     = rr_q;
    if (fifo_pop) begin
      gnt_d  = pick ? 2'b10 : 2'b01;
      data_d = fifo_rdata;
      rr_d   = ~pick;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_OFF;
      trng_en_q   <= 1'b0;
      err_q       <= 1'b0;
      warm_cnt_q  <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      last_byte_q <= '0;
      rep_cnt_q   <= '0;
      gnt_q       <= '0;
      data_q      <= '0;
      rr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      trng_en_q   <= trng_en_d;
      err_q       <= err_d;
      warm_cnt_q  <= warm_cnt_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      last_byte_q <= last_byte_d;
      rep_cnt_q   <= rep_cnt_d;
      gnt_q       <= gnt_d;
      data_q      <= data_d;
      rr_q        <= rr_d;
    end
  end

  cellrv32_trng_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i ({trng_data_i, asm_q}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
